seq_pattern_tx: RTL and testbench
=================================

// Module: seq_pattern_tx
// PURPOSE
// - Serial pattern transmitter: the drive end of the single-bit serial sequence link whose receive end is the 1011 sequence detector.
// - Loads a PAT_W-bit pattern, shifts it out MSB-first for a programmed number of repetitions, and inserts a programmable idle gap between repetitions.
// - Used as stimulus source and link driver in front of the sequence detectors.
// - Outputs change on posedge clk, so a negedge-sampling receiver always sees a stable bit.
// PARAMETERS
// - PAT_W  4  pattern width in bits (>=2)
// - CNT_W  8  width of the repetition count
// - GAP_W  4  width of the inter-repetition idle gap count
// PORTS
// - clk          in   1      clock; all registers update on posedge
// - rst          in   1      reset, synchronous, active-high
// - start_valid  in   1      request to start a transfer
// - start_ready  out  1      high only in IDLE; the transfer is accepted on start_valid & start_ready
// - pattern      in   PAT_W  pattern to send (e.g. 4'b1011); sampled only at accept
// - reps         in   CNT_W  number of pattern repetitions; sampled only at accept
// - gap          in   GAP_W  idle cycles between repetitions; sampled only at accept
// - x            out  1      serial data; 0 whenever x_valid=0
// - x_valid      out  1      x carries a pattern bit this cycle
// - sof          out  1      x is the MSB (first bit) of a repetition
// - busy         out  1      high in SEND, GAP and DONE
// - done         out  1      one-cycle pulse when a transfer completes
// BEHAVIOUR
// - Reset (sync): state=IDLE; x=0, x_valid=0, sof=0, busy=0, done=0; start_ready=1 from the first cycle after reset.
// - Reset mid-transfer: abort; reset values take effect on the next edge; no done pulse.
// - FSM states: IDLE, SEND, GAP, DONE. Registered outputs; start_ready is decoded from the state.
// - IDLE -> SEND on accept with reps!=0. Latch pattern, reps and gap; bit idx=PAT_W-1.
// - IDLE -> DONE on accept with reps==0. No bits are sent.
// - SEND: x=pat[idx], x_valid=1, sof=(idx==PAT_W-1). idx decrements each cycle.
// - SEND at idx==0, last repetition -> DONE.
// - SEND at idx==0, more repetitions, gap==0 -> SEND with idx=PAT_W-1 (back-to-back repetitions).
// - SEND at idx==0, more repetitions, gap!=0 -> GAP for exactly gap cycles, then SEND.
// - GAP: x=0, x_valid=0, sof=0.
// - DONE: lasts one cycle; done=1, x_valid=0; then IDLE.
// - Latency: the first bit appears in the cycle right after the accept edge.
// - The transfer occupies reps*PAT_W + (reps-1)*gap cycles.
// - done is asserted in the cycle after the last bit.
// - The next accept is possible in the cycle after done, giving 1 idle cycle minimum between transfers.
// - start_valid while busy is ignored. Changes to pattern, reps or gap during a transfer have no effect.
// - The repetition counter is CNT_W wide: reps=2^CNT_W-1 is the maximum, with no wrap.
// - The idx counter is ceil(log2(PAT_W)) wide and reloads at every repetition boundary.
// TESTING
// - T1: pattern=1011, reps=1, gap=0 -> x=1,0,1,1 over cycles 1-4; x_valid 1 in cycles 1-4; sof in cycle 1 only; done in cycle 5; start_ready in cycle 6.
// - T2: pattern=1011, reps=3, gap=0 -> x=101110111011 over 12 contiguous cycles; sof in cycles 1, 5, 9; done in cycle 13.
// - T3: pattern=1011, reps=2, gap=2 -> 1011, then 2 cycles with x_valid=0 and x=0, then 1011; done in cycle 11.
// - T4: reps=0 -> x_valid never asserts; done in cycle 1; busy high in cycle 1 only; start_ready low in cycle 1.
// - T5: reps=2, rst asserted while the 3rd bit is on x -> the next cycle has all outputs at reset values and no done; a new start in the following cycle is accepted normally.
// - T6: start_valid held high with pattern toggling 1011/0100 during a transfer -> the transfer is unaffected; a new transfer with the then-current pattern starts in the cycle after done+1.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first for a
// programmed number of repetitions, with an optional idle gap between them.
module seq_pattern_tx #(
   parameter int unsigned PAT_W = 4,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned GAP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] reps,
   input  logic [GAP_W-1:0] gap,
   output logic             x,
   output logic             x_valid,
   output logic             sof,
   output logic             busy,
   output logic             done
);

   localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_GAP,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [CNT_W-1:0]   reps_q, reps_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [GAP_W-1:0]   gcnt_q, gcnt_d;
   logic               x_d, x_valid_d, sof_d, busy_d, done_d;

   // Ready is a pure decode of the current state
   assign start_ready = (state_q == S_IDLE);

   // Next-state, counters and latched transfer parameters
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pat_d   = pat_q;
      reps_d  = reps_q;
      gap_d   = gap_q;
      gcnt_d  = gcnt_q;
      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               pat_d   = pattern;
               reps_d  = reps;
               gap_d   = gap;
               idx_d   = IDX_TOP;
               state_d = (reps == '0) ? S_DONE : S_SEND;
            end
         end
         S_SEND: begin
            if (idx_q == '0) begin
               if (reps_q == CNT_W'(1)) begin
                  state_d = S_DONE;
               end else begin
                  reps_d = reps_q - CNT_W'(1);
                  idx_d  = IDX_TOP;
                  if (gap_q != '0) begin
                     state_d = S_GAP;
                     gcnt_d  = gap_q;
                  end
               end
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         S_GAP: begin
            if (gcnt_q == GAP_W'(1)) begin
               state_d = S_SEND;
            end else begin
               gcnt_d = gcnt_q - GAP_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output values for the upcoming state, registered below so they are glitch-free
   always_comb begin
      x_d       = 1'b0;
      x_valid_d = 1'b0;
      sof_d     = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      case (state_d)
         S_SEND: begin
            x_d       = pat_d[idx_d];
            x_valid_d = 1'b1;
            sof_d     = (idx_d == IDX_TOP);
            busy_d    = 1'b1;
         end
         S_GAP: begin
            busy_d = 1'b1;
         end
         S_DONE: begin
            busy_d = 1'b1;
            done_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // State, counters and output registers; reset aborts any transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         pat_q   <= '0;
         reps_q  <= '0;
         gap_q   <= '0;
         gcnt_q  <= '0;
         x       <= 1'b0;
         x_valid <= 1'b0;
         sof     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pat_q   <= pat_d;
         reps_q  <= reps_d;
         gap_q   <= gap_d;
         gcnt_q  <= gcnt_d;
         x       <= x_d;
         x_valid <= x_valid_d;
         sof     <= sof_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: expected per-cycle output traces are built from
// the transfer rules (bits, gaps, done) and compared every cycle.
module tb_seq_pattern_tx;

   localparam int unsigned PAT_W = 4;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned GAP_W = 4;

   // Observed/expected vector layout: {x, x_valid, sof, busy, done, start_ready}
   localparam logic [5:0] V_IDLE = 6'b000001;
   localparam logic [5:0] V_GAP  = 6'b000100;
   localparam logic [5:0] V_DONE = 6'b000110;

   logic             clk;
   logic             rst;
   logic             start_valid;
   logic             start_ready;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] reps;
   logic [GAP_W-1:0] gap;
   logic             x;
   logic             x_valid;
   logic             sof;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   logic [5:0] exp_q[$];

   seq_pattern_tx #(
      .PAT_W(PAT_W),
      .CNT_W(CNT_W),
      .GAP_W(GAP_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_valid(start_valid),
      .start_ready(start_ready),
      .pattern    (pattern),
      .reps       (reps),
      .gap        (gap),
      .x          (x),
      .x_valid    (x_valid),
      .sof        (sof),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input logic [5:0] expv, input string tag);
      logic [5:0] obs;
      obs = {x, x_valid, sof, busy, done, start_ready};
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed {x,xv,sof,busy,done,rdy}=%b expected %b", tag, obs, expv);
      end
   endtask

   // Expected trace for one transfer, one entry per cycle after the accept edge
   task automatic build(input logic [PAT_W-1:0] p, input int r, input int g);
      exp_q.delete();
      for (int k = 0; k < r; k++) begin
         for (int b = PAT_W - 1; b >= 0; b--)
            exp_q.push_back({p[b], 1'b1, (b == PAT_W - 1), 1'b1, 1'b0, 1'b0});
         if (k < r - 1)
            for (int j = 0; j < g; j++) exp_q.push_back(V_GAP);
      end
      exp_q.push_back(V_DONE);
   endtask

   // Called at an idle negedge; returns at the next idle negedge after done
   task automatic run_xfer(input logic [PAT_W-1:0] p, input int r, input int g,
                           input bit noise, input string tag);
      build(p, r, g);
      check(V_IDLE, {tag, "_idle"});
      pattern     = p;
      reps        = CNT_W'(r);
      gap         = GAP_W'(g);
      start_valid = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         check(exp_q[i], $sformatf("%s[%0d]", tag, i + 1));
         start_valid = noise;
         pattern     = noise ? ((i % 2 == 0) ? 4'b0100 : 4'b1011) : PAT_W'($urandom);
         reps        = CNT_W'($urandom);
         gap         = GAP_W'($urandom);
      end
      @(negedge clk);
      start_valid = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      start_valid = 1'b0;
      pattern     = '0;
      reps        = '0;
      gap         = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check(V_IDLE, "reset");
      @(negedge clk);

      // T1..T4 directed transfers
      run_xfer(4'b1011, 1, 0, 1'b0, "t1");
      run_xfer(4'b1011, 3, 0, 1'b0, "t2");
      run_xfer(4'b1011, 2, 2, 1'b0, "t3");
      run_xfer(4'b1011, 0, 0, 1'b0, "t4");

      // T5: reset while the 3rd bit is on the line
      check(V_IDLE, "t5_idle");
      pattern = 4'b1011; reps = 8'd2; gap = 4'd0; start_valid = 1'b1;
      @(negedge clk); start_valid = 1'b0; check(6'b111100, "t5[1]");
      @(negedge clk); check(6'b010100, "t5[2]");
      @(negedge clk); check(6'b110100, "t5[3]"); rst = 1'b1;
      @(negedge clk); rst = 1'b0; check(V_IDLE, "t5_rst");
      run_xfer(4'b0110, 1, 0, 1'b0, "t5_restart");

      // T6: start_valid held high with toggling pattern, then back-to-back start
      run_xfer(4'b1011, 2, 1, 1'b1, "t6");
      run_xfer(4'b0100, 1, 0, 1'b0, "t6_next");

      // Boundaries: maximum gap, maximum repetitions, constant patterns
      run_xfer(4'b1001, 2, 15, 1'b0, "gap_max");
      run_xfer(4'b1111, 255, 0, 1'b0, "reps_max");
      run_xfer(4'b0000, 2, 1, 1'b0, "zeros");

      // Randomized transfers
      for (int n = 0; n < 30; n++) begin
         logic [PAT_W-1:0] rp;
         int rr, rg;
         bit rn;
         rp = PAT_W'($urandom);
         rr = int'($urandom_range(0, 5));
         rg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
         rn = 1'($urandom_range(0, 1));
         run_xfer(rp, rr, rg, rn, $sformatf("rnd%0d", n));
      end

      check(V_IDLE, "final_idle");
      @(negedge clk);
      check(V_IDLE, "final_idle2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
